// File: rtl/instr_mem_boot.sv
// Instruction memory with a valid/ready boot loader. The CPU stays stalled until a load completes.
// After that the memory serves combinational fetches and accepts CPU writes.
module instr_mem_boot #(
  parameter int          DATA_SIZE    = 32,
  parameter int          ADDRESS_SIZE = 5,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             address,
  output logic [DATA_SIZE-1:0]    data_out,
  input  logic [DATA_SIZE-1:0]    data_in,
  input  logic                    write,
  output logic                    fetch_fault,
  output logic                    cpu_stall,
  input  logic                    ld_start,
  input  logic [ADDRESS_SIZE:0]   ld_len,
  input  logic                    ld_valid,
  input  logic [DATA_SIZE-1:0]    ld_data,
  output logic                    ld_ready,
  output logic                    ld_done,
  output logic [DATA_SIZE-1:0]    ld_checksum,
  output logic [ADDRESS_SIZE:0]   ld_count
);
  localparam int DEPTH = 2 ** ADDRESS_SIZE;
  localparam int CW    = ADDRESS_SIZE + 1;

  localparam logic [1:0] S_BOOT_WAIT = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           len_q, len_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DATA_SIZE-1:0]    sum_q, sum_d;
  logic                    done_q, done_d;

  logic [DATA_SIZE-1:0]    mem [DEPTH];
  logic [ADDRESS_SIZE-1:0] cpu_idx;
  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] mem_widx;
  logic [DATA_SIZE-1:0]    mem_wdata;
  logic [CW-1:0]           start_len;

  assign cpu_idx     = address[ADDRESS_SIZE+1:2];
  assign fetch_fault = (address[1:0] != 2'b00) || (|address[31:ADDRESS_SIZE+2]);
  assign cpu_stall   = (state_q != S_RUN);
  assign ld_ready    = (state_q == S_LOAD);
  assign ld_done     = done_q;
  assign ld_checksum = sum_q;
  assign ld_count    = count_q;
  assign data_out    = cpu_stall ? NOP_WORD[DATA_SIZE-1:0] : mem[cpu_idx];
  assign start_len   = (ld_len > CW'(DEPTH)) ? CW'(DEPTH) : ld_len;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    sum_d     = sum_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = cpu_idx;
    mem_wdata = data_in;
    case (state_q)
      S_BOOT_WAIT, S_RUN: begin
        // CPU write commits even when a reload starts in the same cycle
        mem_we = (state_q == S_RUN) && write && !fetch_fault;
        if (ld_start) begin
          len_d   = start_len;
          count_d = '0;
          sum_d   = '0;
          if (start_len == '0) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_widx  = count_q[ADDRESS_SIZE-1:0];
          mem_wdata = ld_data;
          count_d   = count_q + 1'b1;
          sum_d     = sum_q + ld_data;
          if (count_d == len_q) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_BOOT_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT_WAIT;
      len_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  end

  // Array contents survive reset so a partial load stays visible.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end
endmodule

// File: tb/tb_instr_mem_boot.sv
// Bench for instr_mem_boot: table vectors, directed corner sequences, then random traffic vs. a model.
module tb_instr_mem_boot;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address, data_out, data_in, ld_data, ld_checksum;
  logic        write, fetch_fault, cpu_stall, ld_start, ld_valid, ld_ready, ld_done;
  logic [5:0]  ld_len, ld_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_mem_boot #(.DATA_SIZE(32), .ADDRESS_SIZE(5), .NOP_WORD(32'h13)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_out(data_out), .data_in(data_in),
    .write(write), .fetch_fault(fetch_fault), .cpu_stall(cpu_stall), .ld_start(ld_start),
    .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_checksum(ld_checksum), .ld_count(ld_count)
  );

  // Reference model: loader progress as plain counters, memory as an array
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_run, m_loading, m_done;
  int          m_len, m_cnt;
  logic [31:0] m_sum;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 7) != 0);
  endfunction

  task automatic m_reset();
    m_run = 0; m_loading = 0; m_done = 0; m_cnt = 0; m_sum = 0; m_len = 0;
  endtask

  task automatic m_begin_load();
    m_len = (int'(ld_len) > DEPTH) ? DEPTH : int'(ld_len);
    m_cnt = 0;
    m_sum = 0;
    if (m_len == 0) begin m_run = 1; m_loading = 0; m_done = 1; end
    else            begin m_run = 0; m_loading = 1; end
  endtask

  task automatic m_step();
    int idx;
    idx = int'(address >> 2) % DEPTH;
    m_done = 0;
    if (m_loading) begin
      if (ld_valid) begin
        m_mem[m_cnt % DEPTH] = ld_data;
        m_known[m_cnt % DEPTH] = 1;
        m_sum += ld_data;
        m_cnt++;
        if (m_cnt == m_len) begin m_loading = 0; m_run = 1; m_done = 1; end
      end
    end else begin
      if (m_run && write && !m_fault(address)) begin
        m_mem[idx] = data_in;
        m_known[idx] = 1;
      end
      if (ld_start) m_begin_load();
    end
  endtask

  task automatic m_cmp();
    int idx;
    idx = int'(address >> 2) % DEPTH;
    chk("stall", 32'(cpu_stall), 32'(!m_run));
    chk("ready", 32'(ld_ready), 32'(m_loading));
    chk("done", 32'(ld_done), 32'(m_done));
    chk("count", 32'(ld_count), 32'(m_cnt));
    chk("checksum", ld_checksum, m_sum);
    chk("fault", 32'(fetch_fault), 32'(m_fault(address)));
    if (!m_run) chk("nop", data_out, 32'h13);
    else if (m_known[idx]) chk("data_out", data_out, m_mem[idx]);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle(); m_cmp(); adv();
  endtask

  task automatic idle_in();
    ld_start = 0; ld_valid = 0; write = 0; ld_len = 0; ld_data = 0; data_in = 0; address = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_reset();
    settle(); m_cmp();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  typedef struct {
    bit st; logic [5:0] len; bit vld; logic [31:0] dat; bit wr; logic [31:0] adr; logic [31:0] din;
    bit e_stall; bit e_ready; bit e_done; logic [5:0] e_cnt; logic [31:0] e_sum; logic [31:0] e_dout;
  } vec_t;

  vec_t vec [11];

  initial begin
    // Load of A,B,C with gaps; start and CPU write mid-load must be ignored
    vec[0]  = '{0, 0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0,            32'h13};
    vec[1]  = '{1, 3, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0,            32'h13};
    vec[2]  = '{0, 0, 0, 0,            0, 0, 0,        1, 1, 0, 0, 0,            32'h13};
    vec[3]  = '{0, 0, 1, 32'h11111111, 0, 0, 0,        1, 1, 0, 0, 0,            32'h13};
    vec[4]  = '{0, 0, 0, 0,            0, 0, 0,        1, 1, 0, 1, 32'h11111111, 32'h13};
    vec[5]  = '{1, 9, 1, 32'h22222222, 1, 0, 32'hBAD,  1, 1, 0, 1, 32'h11111111, 32'h13};
    vec[6]  = '{0, 0, 0, 0,            0, 0, 0,        1, 1, 0, 2, 32'h33333333, 32'h13};
    vec[7]  = '{0, 0, 1, 32'h33333333, 0, 0, 0,        1, 1, 0, 2, 32'h33333333, 32'h13};
    vec[8]  = '{0, 0, 0, 0,            0, 0, 0,        0, 0, 1, 3, 32'h66666666, 32'h11111111};
    vec[9]  = '{0, 0, 0, 0,            0, 4, 0,        0, 0, 0, 3, 32'h66666666, 32'h22222222};
    vec[10] = '{0, 0, 0, 0,            0, 8, 0,        0, 0, 0, 3, 32'h66666666, 32'h33333333};

    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    idle_in();
    do_reset();

    for (int i = 0; i < 11; i++) begin
      ld_start = vec[i].st; ld_len = vec[i].len; ld_valid = vec[i].vld; ld_data = vec[i].dat;
      write = vec[i].wr; address = vec[i].adr; data_in = vec[i].din;
      settle();
      chk($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'(vec[i].e_stall));
      chk($sformatf("vec%0d_ready", i), 32'(ld_ready), 32'(vec[i].e_ready));
      chk($sformatf("vec%0d_done", i), 32'(ld_done), 32'(vec[i].e_done));
      chk($sformatf("vec%0d_count", i), 32'(ld_count), 32'(vec[i].e_cnt));
      chk($sformatf("vec%0d_sum", i), ld_checksum, vec[i].e_sum);
      chk($sformatf("vec%0d_dout", i), data_out, vec[i].e_dout);
      adv();
    end
    idle_in();

    // Oversized length clamps to a full-depth load
    ld_start = 1; ld_len = 40; tick(); ld_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1; ld_data = $urandom; tick();
    end
    settle();
    chk("clamp_count", 32'(ld_count), 32'd32);
    chk("clamp_done", 32'(ld_done), 32'd1);
    chk("clamp_stall", 32'(cpu_stall), 32'd0);
    adv();
    ld_valid = 0; tick();

    // CPU write, then a misaligned write that must be dropped
    write = 1; address = 8; data_in = 32'hDEADBEEF; tick();
    write = 0; settle(); chk("wr_readback", data_out, 32'hDEADBEEF); adv();
    write = 1; address = 9; data_in = 32'h12345678;
    settle(); chk("misalign_fault", 32'(fetch_fault), 32'd1); adv();
    write = 0; address = 8;
    settle(); chk("misalign_dropped", data_out, 32'hDEADBEEF); adv();
    address = 32'h80;
    settle(); chk("range_fault", 32'(fetch_fault), 32'd1); m_cmp(); adv();
    idle_in();

    // Zero-length load goes straight to RUN
    do_reset();
    ld_start = 1; ld_len = 0; tick(); ld_start = 0;
    settle();
    chk("zero_stall", 32'(cpu_stall), 32'd0);
    chk("zero_done", 32'(ld_done), 32'd1);
    chk("zero_count", 32'(ld_count), 32'd0);
    adv();
    settle(); chk("zero_done_once", 32'(ld_done), 32'd0); adv();

    // Reset mid-load, then full reload
    ld_start = 1; ld_len = 4; tick(); ld_start = 0;
    ld_valid = 1; ld_data = 32'hFFFF0000; tick();
    ld_data = 32'hFFFF0001; tick();
    ld_valid = 0;
    do_reset();
    chk("abort_stall", 32'(cpu_stall), 32'd1);
    ld_start = 1; ld_len = 4; tick(); ld_start = 0;
    for (int i = 1; i <= 4; i++) begin
      ld_valid = 1; ld_data = 32'(i) << 12; tick();
    end
    ld_valid = 0;
    settle();
    chk("reload_sum", ld_checksum, 32'hA000);
    chk("reload_count", 32'(ld_count), 32'd4);
    adv();
    for (int i = 0; i < 4; i++) begin
      address = 32'(i * 4);
      settle(); chk($sformatf("reload_word%0d", i), data_out, 32'(i + 1) << 12); adv();
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        idle_in(); do_reset();
      end
      ld_start = ($urandom_range(0, 39) == 0);
      ld_len   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 8));
      ld_valid = $urandom_range(0, 1);
      ld_data  = $urandom;
      write    = ($urandom_range(0, 2) == 0);
      data_in  = $urandom;
      address  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : {25'd0, 5'($urandom), 2'b00};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
